canny_grad: RTL

- Sobel gradient producer that drives the `cannyX`/`cannyY` inputs of the Canny magnitude stage.
- Accepts a raster-order 8-bit greyscale pixel stream after a `startEn` pulse.
- Buffers two image lines plus a 3x3 window and emits signed 9-bit X/Y gradients, one per interior pixel.
- Emits gradients only for centre addresses inside the `STARTADDRESS`..`ENDADDRESS` window.

---
 rtl/canny_grad.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/canny_grad.sv
// Sobel X/Y gradient producer feeding the Canny magnitude stage.
// Optional `CANNY_GRAD_SAT_EN: clamp raw gradients to +/-255 instead of the >>>2 scaling.
module canny_grad #(
   parameter int IMGWIDTH     = 512,
   parameter int IMGHEIGHT    = 512,
   parameter int STARTADDRESS = 513,
   parameter int ENDADDRESS   = 261630,
   parameter int ADDRW        = 18
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    startEn,
   input  logic [7:0]              pixelIn,
   input  logic                    pixelValid,
   output logic signed [8:0]       cannyX,
   output logic signed [8:0]       cannyY,
   output logic                    gradValid,
   output logic [ADDRW-1:0]        gradAddr,
   output logic                    busy,
   output logic                    done
);

   // state | meaning
   // IDLE  | waiting for startEn, pixelValid ignored
   // RUN   | accepting pixels of the frame
   // DRAIN | two cycles letting the gradient pipeline empty
   // DONE  | one-cycle done pulse

   localparam int COLW = $clog2(IMGWIDTH);
   localparam int ROWW = $clog2(IMGHEIGHT);
   localparam logic [ADDRW-1:0] LAST_PIX  = ADDRW'(IMGWIDTH * IMGHEIGHT - 1);
   localparam logic [ADDRW-1:0] CTR_OFS   = ADDRW'(IMGWIDTH + 1);
   localparam logic [ADDRW-1:0] START_A   = ADDRW'(STARTADDRESS);
   localparam logic [ADDRW-1:0] END_A     = ADDRW'(ENDADDRESS);
   localparam logic [COLW-1:0]  COL_LAST  = COLW'(IMGWIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nx;
   logic              drain_cnt;
   logic [ADDRW-1:0]  pix_cnt;
   logic [COLW-1:0]   col;
   logic [ROWW-1:0]   row;
   logic              accept;
   logic [ADDRW-1:0]  centre;

   logic [7:0]        lb_top [IMGWIDTH];
   logic [7:0]        lb_mid [IMGWIDTH];
   logic [7:0]        win [3][3];
   logic              win_valid;
   logic [ADDRW-1:0]  win_addr;

   logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
   logic signed [10:0] raw_x, raw_y;
   logic               s1_valid;
   logic [ADDRW-1:0]   s1_addr;

   assign accept = (state == RUN) && pixelValid;
   assign centre = pix_cnt - CTR_OFS;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (startEn) state_nx = RUN;
         RUN:     if (accept && (pix_cnt == LAST_PIX)) state_nx = DRAIN;
         DRAIN:   if (drain_cnt) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DRAIN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_cnt   <= '0;
         col       <= '0;
         row       <= '0;
         drain_cnt <= 1'b0;
      end else begin
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         if (state == IDLE && startEn) begin
            pix_cnt <= '0;
            col     <= '0;
            row     <= '0;
         end else if (accept) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Line buffers hold the two rows above the incoming pixel; no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_top[col] <= lb_mid[col];
         lb_mid[col] <= pixelIn;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
               win[r][k] <= '0;
         win_valid <= 1'b0;
         win_addr  <= '0;
      end else begin
         win_valid <= accept && (col >= COLW'(2)) && (row >= ROWW'(2))
                      && (centre >= START_A) && (centre <= END_A);
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= lb_top[col];
            win[1][2] <= lb_mid[col];
            win[2][2] <= pixelIn;
            win_addr  <= centre;
         end
      end
   end

   assign gx_pos = {3'b0, win[0][2]} + {2'b0, win[1][2], 1'b0} + {3'b0, win[2][2]};
   assign gx_neg = {3'b0, win[0][0]} + {2'b0, win[1][0], 1'b0} + {3'b0, win[2][0]};
   assign gy_pos = {3'b0, win[2][0]} + {2'b0, win[2][1], 1'b0} + {3'b0, win[2][2]};
   assign gy_neg = {3'b0, win[0][0]} + {2'b0, win[0][1], 1'b0} + {3'b0, win[0][2]};

   always_ff @(posedge clk) begin
      if (reset) begin
         raw_x    <= '0;
         raw_y    <= '0;
         s1_valid <= 1'b0;
         s1_addr  <= '0;
      end else begin
         raw_x    <= $signed(gx_pos - gx_neg);
         raw_y    <= $signed(gy_pos - gy_neg);
         s1_valid <= win_valid;
         s1_addr  <= win_addr;
      end
   end

`ifdef CANNY_GRAD_SAT_EN
   function automatic logic signed [8:0] to_out(input logic signed [10:0] v);
      if (v > 11'sd255)       return 9'sd255;
      else if (v < -11'sd255) return -9'sd255;
      else                    return v[8:0];
   endfunction
`else
   function automatic logic signed [8:0] to_out(input logic signed [10:0] v);
      return 9'(v >>> 2);
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cannyX    <= '0;
         cannyY    <= '0;
         gradValid <= 1'b0;
         gradAddr  <= '0;
      end else begin
         gradValid <= s1_valid;
         if (s1_valid) begin
            cannyX   <= to_out(raw_x);
            cannyY   <= to_out(raw_y);
            gradAddr <= s1_addr;
         end
      end
   end

endmodule
